// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared types, control bundle and register-compare helper for the pipeline sequencer
package pipeline_ctrl_pkg;
  typedef logic [4:0] regbits_t;
  typedef enum logic [1:0] {PC_RUN, PC_MWAIT, PC_DRAIN, PC_HALTED} pctl_state_t;
  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_flush;
    logic exmem_en;
    logic exmem_flush;
    logic memwb_en;
    logic memwb_flush;
  } pctl_ctl_t;
  localparam int PCTL_WAIT_MAX = 255;
  localparam int PCTL_WAIT_W = $clog2(PCTL_WAIT_MAX + 1);
  localparam pctl_ctl_t CTL_RUN   = pctl_ctl_t'(9'b1_10_10_10_10);
  localparam pctl_ctl_t CTL_RST   = pctl_ctl_t'(9'b0_01_01_01_01);
  localparam pctl_ctl_t CTL_MWAIT = pctl_ctl_t'(9'b0_00_00_00_11);
  localparam pctl_ctl_t CTL_HALT  = pctl_ctl_t'(9'b0_00_00_00_00);
  // $zero never carries a dependence
  function automatic logic raw(regbits_t w, regbits_t rs, regbits_t rt, logic use_rt);
    return (w != '0) && ((w == rs) || (use_rt && (w == rt)));
  endfunction
endpackage

// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: datapath <-> sequencer bundle
//   slave  (sequencer): takes latch status, drives latch en/flush, pc_en, halted, mem_timeout, state_o
//   master (datapath) : the mirror image
interface pipeline_ctrl_if;
  import pipeline_ctrl_pkg::*;
  logic        ihit;
  logic        dhit;
  logic        exmem_ren;
  logic        exmem_wen;
  regbits_t    ifid_rs;
  regbits_t    ifid_rt;
  logic        ifid_use_rt;
  logic        ifid_halt;
  regbits_t    idex_wsel;
  logic        idex_regwr;
  logic        idex_memread;
  regbits_t    exmem_wsel;
  logic        exmem_regwr;
  logic        ex_redirect;
  logic        memwb_halt;
  logic        pc_en;
  logic        ifid_en;
  logic        ifid_flush;
  logic        idex_en;
  logic        idex_flush;
  logic        exmem_en;
  logic        exmem_flush;
  logic        memwb_en;
  logic        memwb_flush;
  logic        halted;
  logic        mem_timeout;
  pctl_state_t state_o;
  modport slave (
    input  ihit, dhit, exmem_ren, exmem_wen, ifid_rs, ifid_rt, ifid_use_rt, ifid_halt,
           idex_wsel, idex_regwr, idex_memread, exmem_wsel, exmem_regwr, ex_redirect, memwb_halt,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush,
           memwb_en, memwb_flush, halted, mem_timeout, state_o
  );
  modport master (
    output ihit, dhit, exmem_ren, exmem_wen, ifid_rs, ifid_rt, ifid_use_rt, ifid_halt,
           idex_wsel, idex_regwr, idex_memread, exmem_wsel, exmem_regwr, ex_redirect, memwb_halt,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush,
           memwb_en, memwb_flush, halted, mem_timeout, state_o
  );
endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// pipeline_ctrl_hazard_detect: combinational RAW/load-use stall request for the ID stage
//   in : ID sources (rs, rt, use_rt), EX writer (wsel, regwr, memread), MEM writer (wsel, regwr)
//   out: hz
//   PCTL_FWD_EN defined: forwarding covers everything except a load feeding the next instruction
module pipeline_ctrl_hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  regbits_t ifid_rs,
  input  regbits_t ifid_rt,
  input  logic     ifid_use_rt,
  input  regbits_t idex_wsel,
  input  logic     idex_regwr,
  input  logic     idex_memread,
  input  regbits_t exmem_wsel,
  input  logic     exmem_regwr,
  output logic     hz
);
`ifdef PCTL_FWD_EN
  logic unused_mem;
  assign unused_mem = ^{exmem_wsel, exmem_regwr};
  assign hz = idex_memread & idex_regwr & raw(idex_wsel, ifid_rs, ifid_rt, ifid_use_rt);
`else
  logic unused_ld;
  assign unused_ld = idex_memread;
  assign hz = (idex_regwr & raw(idex_wsel, ifid_rs, ifid_rt, ifid_use_rt))
            | (exmem_regwr & raw(exmem_wsel, ifid_rs, ifid_rt, ifid_use_rt));
`endif
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: 5-stage pipeline sequencer (dmem wait, redirect, hazard, imiss, halt drain)
//   CLK, RST (sync, active-high); bus: pipeline_ctrl_if.slave
//   WAIT_MAX: MWAIT cycles before mem_timeout sets; PCTL_FWD_EN selects the hazard rule
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = PCTL_WAIT_MAX
) (
  input logic           CLK,
  input logic           RST,
  pipeline_ctrl_if.slave bus
);
  localparam int W = $clog2(WAIT_MAX + 1);
  pctl_state_t state_q, state_d;
  logic [W-1:0] wait_cnt_q, wait_cnt_d;
  logic halted_q, halted_d, mem_timeout_q, mem_timeout_d;
  logic hz, mwait;
  pctl_ctl_t ctl;
  pipeline_ctrl_hazard_detect u_hz (
    .ifid_rs      (bus.ifid_rs),
    .ifid_rt      (bus.ifid_rt),
    .ifid_use_rt  (bus.ifid_use_rt),
    .idex_wsel    (bus.idex_wsel),
    .idex_regwr   (bus.idex_regwr),
    .idex_memread (bus.idex_memread),
    .exmem_wsel   (bus.exmem_wsel),
    .exmem_regwr  (bus.exmem_regwr),
    .hz           (hz)
  );
  assign mwait = (bus.exmem_ren | bus.exmem_wen) & ~bus.dhit;
  always_comb begin
    ctl = CTL_RUN;
    state_d = state_q;
    if (state_q == PC_HALTED) begin
      ctl = CTL_HALT;
    end else if (mwait) begin
      ctl = CTL_MWAIT;
      state_d = (state_q == PC_RUN) ? PC_MWAIT : state_q;
    end else if (state_q == PC_DRAIN) begin
      ctl.pc_en = 1'b0;
      ctl.ifid_flush = 1'b1;
      state_d = bus.memwb_halt ? PC_HALTED : PC_DRAIN;
    end else begin
      // RUN, or MWAIT whose access just completed: normal priority chain
      state_d = PC_RUN;
      if (bus.ex_redirect) begin
        ctl.ifid_flush = 1'b1;
        ctl.idex_flush = 1'b1;
      end else if (hz) begin
        ctl.pc_en = 1'b0;
        ctl.ifid_en = 1'b0;
        ctl.idex_flush = 1'b1;
      end else if (!bus.ihit) begin
        ctl.pc_en = 1'b0;
        ctl.ifid_flush = 1'b1;
      end else if (bus.ifid_halt) begin
        state_d = PC_DRAIN;
      end
    end
    if (RST) ctl = CTL_RST;
    wait_cnt_d = (state_q == PC_MWAIT && mwait)
               ? ((wait_cnt_q == W'(WAIT_MAX)) ? wait_cnt_q : wait_cnt_q + 1'b1) : '0;
    mem_timeout_d = mem_timeout_q | (wait_cnt_d == W'(WAIT_MAX));
    halted_d = halted_q | (state_d == PC_HALTED);
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= PC_RUN;
      wait_cnt_q <= '0;
      halted_q <= 1'b0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_cnt_q <= wait_cnt_d;
      halted_q <= halted_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end
  assign bus.pc_en       = ctl.pc_en;
  assign bus.ifid_en     = ctl.ifid_en;
  assign bus.ifid_flush  = ctl.ifid_flush;
  assign bus.idex_en     = ctl.idex_en;
  assign bus.idex_flush  = ctl.idex_flush;
  assign bus.exmem_en    = ctl.exmem_en;
  assign bus.exmem_flush = ctl.exmem_flush;
  assign bus.memwb_en    = ctl.memwb_en;
  assign bus.memwb_flush = ctl.memwb_flush;
  assign bus.halted      = halted_q;
  assign bus.mem_timeout = mem_timeout_q;
  assign bus.state_o     = state_q;
endmodule
